// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_QDEPTH = 2;

    typedef logic [1:0] qcount_t;

    // Room exists when queued plus in-flight entries, less this cycle's pop, stay below depth.
    function automatic logic has_room(qcount_t count, logic pend, logic pop);
        return ({1'b0, count} + {2'b00, pend}) < (3'(FETCH_QDEPTH) + {2'b00, pop});
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction queue holding {pc, data}; head is always slot 0.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [PC_W-1:0]   push_pc,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output qcount_t           count,
    output logic              head_valid,
    output logic [PC_W-1:0]   head_pc,
    output logic [DATA_W-1:0] head_data
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t head_q;
    entry_t tail_q;
    entry_t incoming;

    always_comb begin
        incoming = '{pc: push_pc, data: push_data};
    end

    // Vacated slots are zeroed so an empty queue presents pc/data of 0.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            count  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head_q <= incoming;
                    else               tail_q <= incoming;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    tail_q <= '0;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= incoming;
                    end else begin
                        head_q <= incoming;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        head_valid = (count != 2'd0);
        head_pc    = head_q.pc;
        head_data  = head_q.data;
    end

    no_overflow: assert property (@(posedge clock) disable iff (reset || flush)
        !(push && !pop && count == 2'd2));

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC generation, read issue to prg_mem, capture into a 2-entry queue, redirect/flush.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned                RAM_WIDTH     = 32,
    parameter int unsigned                RAM_ADDR_BITS = 9,
    parameter logic [RAM_ADDR_BITS-1:0]   RESET_PC      = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [RAM_ADDR_BITS-1:0] redirect_addr,
    output logic                     ram_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     out_data,
    output logic                     inst_valid,
    output logic [RAM_WIDTH-1:0]     inst_data,
    output logic [RAM_ADDR_BITS-1:0] inst_pc,
    input  logic                     inst_ready
);

    logic [RAM_ADDR_BITS-1:0] fetch_pc;
    logic [RAM_ADDR_BITS-1:0] pend_pc;
    logic                     pend;
    qcount_t                  count;
    logic                     pop;
    logic                     issue;
    logic                     push;

    always_comb begin
        pop        = inst_valid & inst_ready;
        issue      = !reset && fetch_en && !redirect_valid && has_room(count, pend, pop);
        push       = pend && !redirect_valid;
        ram_enable = issue;
        address    = fetch_pc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            pend     <= 1'b0;
            pend_pc  <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_addr;
            pend     <= 1'b0;
        end else begin
            pend <= issue;
            if (issue) begin
                pend_pc  <= fetch_pc;
                fetch_pc <= fetch_pc + {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    fetch_queue #(
        .DATA_W (RAM_WIDTH),
        .PC_W   (RAM_ADDR_BITS)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (pend_pc),
        .push_data  (out_data),
        .pop        (pop),
        .count      (count),
        .head_valid (inst_valid),
        .head_pc    (inst_pc),
        .head_data  (inst_data)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch against a transaction-level queue model; second instance covers PC wrap.
module tb_inst_fetch;

    localparam int unsigned W  = 32;
    localparam int unsigned AB = 9;

    typedef struct packed {
        logic [AB-1:0] pc;
        logic [W-1:0]  data;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1, fetch_en = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
    logic [AB-1:0] redirect_addr = '0;
    logic          ram_enable, inst_valid;
    logic [AB-1:0] address, inst_pc;
    logic [W-1:0]  out_data = '0, inst_data;

    logic          w_redirect = 1'b0, w_ready = 1'b1;
    logic          w_ram_enable, w_inst_valid;
    logic [AB-1:0] w_address, w_inst_pc;
    logic [W-1:0]  w_out_data = '0, w_inst_data;

    logic [W-1:0]  mem [512];

    inst_fetch #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .RESET_PC(9'd0)) dut (
        .clock(clk), .reset(reset), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .ram_enable(ram_enable), .address(address),
        .out_data(out_data), .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_ready(inst_ready));

    inst_fetch #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .RESET_PC(9'd510)) dut_wrap (
        .clock(clk), .reset(reset), .fetch_en(fetch_en), .redirect_valid(w_redirect),
        .redirect_addr(9'd0), .ram_enable(w_ram_enable), .address(w_address),
        .out_data(w_out_data), .inst_valid(w_inst_valid), .inst_data(w_inst_data),
        .inst_pc(w_inst_pc), .inst_ready(w_ready));

    // Synchronous-read memory; garbage on idle cycles so stray captures are visible.
    always @(posedge clk) begin
        out_data   <= ram_enable   ? mem[address]   : $urandom;
        w_out_data <= w_ram_enable ? mem[w_address] : $urandom;
    end

    int unsigned n_checks = 0, n_pass = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    logic [AB-1:0] m_fetch_pc, m_pend_pc;
    logic          m_pend;
    logic          m_known = 1'b0;
    ent_t          mq[$];

    logic          w_collect = 1'b0;
    logic [AB-1:0] wpcs[$];
    logic [W-1:0]  wdat[$];

    task automatic step(input logic rst, input logic en, input logic rv,
                        input logic [AB-1:0] ra, input logic rdy);
        logic m_valid, m_pop, m_issue;
        ent_t head;
        @(negedge clk);
        reset = rst; fetch_en = en; redirect_valid = rv; redirect_addr = ra; inst_ready = rdy;
        #1;
        m_valid = (mq.size() != 0);
        head    = m_valid ? mq[0] : '0;
        m_pop   = m_valid && rdy;
        m_issue = !rst && en && !rv && ((mq.size() + 32'(m_pend)) < (2 + 32'(m_pop)));
        if (m_known) begin
            check_eq("ram_enable", 32'(ram_enable), 32'(m_issue));
            check_eq("address",    32'(address),    32'(m_fetch_pc));
            check_eq("inst_valid", 32'(inst_valid), 32'(m_valid));
            check_eq("inst_pc",    32'(inst_pc),    32'(head.pc));
            check_eq("inst_data",  inst_data,       head.data);
        end
        if (w_collect && w_inst_valid) begin
            wpcs.push_back(w_inst_pc);
            wdat.push_back(w_inst_data);
        end
        if (rst) begin
            m_fetch_pc = 9'd0; m_pend = 1'b0; m_pend_pc = '0; mq.delete(); m_known = 1'b1;
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (rv) begin
                m_fetch_pc = ra; m_pend = 1'b0; mq.delete();
            end else begin
                if (m_pend) mq.push_back('{pc: m_pend_pc, data: 32'h1000 + 32'(m_pend_pc)});
                if (m_issue) begin
                    m_pend_pc  = m_fetch_pc;
                    m_fetch_pc = m_fetch_pc + 9'd1;
                end
                m_pend = m_issue;
            end
        end
    endtask

    initial begin
        logic [AB-1:0] wexp [4];
        int unsigned   lat;
        logic          found;
        wexp = '{9'd510, 9'd511, 9'd0, 9'd1};
        for (int k = 0; k < 512; k++) mem[k] = 32'h1000 + 32'(k);

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        w_collect = 1'b1;
        repeat (12) step(0, 1, 0, 0, 1);
        w_collect = 1'b0;
        check_eq("wrap_seen", 32'(wpcs.size() >= 4), 32'd1);
        if (wpcs.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                check_eq("wrap_pc",   32'(wpcs[i]), 32'(wexp[i]));
                check_eq("wrap_data", wdat[i],      32'h1000 + 32'(wexp[i]));
            end

        repeat (6) step(0, 1, 0, 0, 0);
        repeat (6) step(0, 1, 0, 0, 1);

        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 9'h40, 0);
        lat = 0; found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, 0, 0, 1);
            if (!found && inst_valid && inst_pc == 9'h40) begin
                found = 1'b1;
                lat   = k;
            end
        end
        check_eq("redirect_latency", lat, 32'd3);

        step(0, 1, 1, 9'h80, 1);
        repeat (6) step(0, 1, 0, 0, 1);

        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        repeat (6) step(0, 1, 0, 0, 1);

        repeat (3) step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        repeat (6) step(0, 1, 0, 0, 1);

        repeat (400)
            step($urandom_range(99) < 2, $urandom_range(99) < 80, $urandom_range(99) < 5,
                 AB'($urandom), $urandom_range(99) < 70);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
